seg_scan_driver: RTL

//   Downstream display stage for the up-counter's 4-bit output. It registers the count,

---
 rtl/seg_scan_driver_if.sv | 21 ++
 rtl/seg_scan_driver.sv | 116 +++++++++++
 2 files changed

// File: rtl/seg_scan_driver_if.sv
// Display-side bus of the segment scan driver: count/mode/blank in, segment and anode drive out.
interface seg_scan_driver_if #(
   parameter int NUM_AN = 8
);
   logic [3:0]        seg_scan_val;
   logic              seg_scan_mode;
   logic              seg_scan_blank;
   logic [6:0]        seg_scan_seg;
   logic              seg_scan_dp;
   logic [NUM_AN-1:0] seg_scan_an;

   modport master (
      output seg_scan_val, seg_scan_mode, seg_scan_blank,
      input  seg_scan_seg, seg_scan_dp, seg_scan_an
   );

   modport slave (
      input  seg_scan_val, seg_scan_mode, seg_scan_blank,
      output seg_scan_seg, seg_scan_dp, seg_scan_an
   );
endinterface

// File: rtl/seg_scan_driver.sv
// Two-digit multiplexed 7-segment driver: digit 0 shows the live count,
// digit 1 counts how many times that count has wrapped past its terminal value.
module seg_scan_driver #(
   parameter int REFRESH_DIV = 100000,
   parameter int NUM_AN      = 8
) (
   input logic             seg_scan_clk,
   input logic             seg_scan_rst,
   seg_scan_driver_if.slave bus
);

   localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

   typedef enum logic {
      DIG_LO = 1'b0,
      DIG_HI = 1'b1
   } digit_t;

   logic [3:0]        val_q;
   logic [3:0]        prev_q;
   logic              mode_q;
   logic [3:0]        hi;
   logic [CW-1:0]     ref_cnt;
   digit_t            idx;
   logic [6:0]        seg_q;
   logic [NUM_AN-1:0] an_q;
   logic              dp_q;

   logic [3:0]        term;
   logic              wrap;
   logic              mode_chg;

   // Active-low hex glyph lookup, segment order {g,f,e,d,c,b,a}.
   function automatic logic [6:0] glyph(input logic [3:0] v);
      case (v)
         4'h0:    glyph = 7'h40;
         4'h1:    glyph = 7'h79;
         4'h2:    glyph = 7'h24;
         4'h3:    glyph = 7'h30;
         4'h4:    glyph = 7'h19;
         4'h5:    glyph = 7'h12;
         4'h6:    glyph = 7'h02;
         4'h7:    glyph = 7'h78;
         4'h8:    glyph = 7'h00;
         4'h9:    glyph = 7'h10;
         4'hA:    glyph = 7'h08;
         4'hB:    glyph = 7'h03;
         4'hC:    glyph = 7'h46;
         4'hD:    glyph = 7'h21;
         4'hE:    glyph = 7'h06;
         default: glyph = 7'h0E;
      endcase
   endfunction

   // Wrap detection: the registered count stepped from terminal back to zero.
   always_comb begin
      term     = mode_q ? 4'd9 : 4'd15;
      wrap     = (prev_q == term) && (val_q == 4'd0);
      mode_chg = (mode_q != bus.seg_scan_mode);
   end

   // Input pipeline and wrap digit; a mode change clears hi ahead of any wrap.
   always_ff @(posedge seg_scan_clk) begin
      if (seg_scan_rst) begin
         val_q  <= '0;
         prev_q <= '0;
         mode_q <= 1'b0;
         hi     <= '0;
      end else begin
         val_q  <= bus.seg_scan_val;
         prev_q <= val_q;
         mode_q <= bus.seg_scan_mode;
         if (mode_chg)
            hi <= '0;
         else if (wrap)
            hi <= (hi == term) ? 4'd0 : hi + 4'd1;
      end
   end

   // Refresh timer: flips the lit digit every REFRESH_DIV cycles.
   always_ff @(posedge seg_scan_clk) begin
      if (seg_scan_rst) begin
         ref_cnt <= '0;
         idx     <= DIG_LO;
      end else if (ref_cnt == CW'(REFRESH_DIV - 1)) begin
         ref_cnt <= '0;
         idx     <= (idx == DIG_LO) ? DIG_HI : DIG_LO;
      end else begin
         ref_cnt <= ref_cnt + 1'b1;
      end
   end

   // Registered segment/anode drive for the currently selected digit.
   always_ff @(posedge seg_scan_clk) begin
      if (seg_scan_rst) begin
         seg_q <= 7'h7F;
         an_q  <= '1;
         dp_q  <= 1'b1;
      end else begin
         dp_q <= 1'b1;
         an_q <= '1;
         if (idx == DIG_LO) begin
            an_q[0] <= 1'b0;
            seg_q   <= glyph(val_q);
         end else begin
            an_q[1] <= 1'b0;
            seg_q   <= (bus.seg_scan_blank && (hi == 4'd0)) ? 7'h7F : glyph(hi);
         end
      end
   end

   assign bus.seg_scan_seg = seg_q;
   assign bus.seg_scan_an  = an_q;
   assign bus.seg_scan_dp  = dp_q;

endmodule
